// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: constants shared by the RAM DMA engine, its address
// generators, its RAM-side interface and the RAM instance it drives.
//   - RAM_ADDR_W / RAM_DATA_W : default RAM geometry (32 x 32-bit)
//   - OP_*                    : command opcode encodings on the op port
//   - ST_*                    : engine FSM state encodings
package ram_dma_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 32;

  // Command opcodes
  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_SUM  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  // Engine FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FILL_W  = 3'd1;
  localparam state_t ST_COPY_R  = 3'd2;
  localparam state_t ST_COPY_W  = 3'd3;
  localparam state_t ST_SUM_R   = 3'd4;
  localparam state_t ST_SUM_ACC = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

endpackage

// File: rtl/ram_dma_engine_if.sv
// ram_dma_engine_if: single-port synchronous RAM bus between the DMA engine
// (master) and one RAM instance (slave). The RAM has a 1-cycle registered
// read and is write-first on the addressed word.
//   mem_address  master->slave  word address
//   mem_wdata    master->slave  RAM data_in
//   mem_writeOn  master->slave  write enable
//   mem_rdata    slave->master  RAM data_out (registered)
interface ram_dma_engine_if
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) ();

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_writeOn;

  modport master (
    output mem_address,
    output mem_wdata,
    output mem_writeOn,
    input  mem_rdata
  );

  modport slave (
    input  mem_address,
    input  mem_wdata,
    input  mem_writeOn,
    output mem_rdata
  );

endinterface

// File: rtl/ram_dma_addr_gen.sv
// ram_dma_addr_gen: base register plus index counter for one DMA address
// stream. Produces (base + index) mod 2**ADDR_W and flags the last index.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture base_in and clear the index
//   base_in    : base address captured on load
//   advance    : step the index by one
//   last_idx   : index value of the final word (len - 1)
//   addr       : current wrapped address
//   last       : current index equals last_idx
module ram_dma_addr_gen
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_in,
  input  logic              advance,
  input  logic [LEN_W-1:0]  last_idx,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  always_comb begin
    base_d = base_q;
    idx_d  = idx_q;
    if (load) begin
      base_d = base_in;
      idx_d  = '0;
    end else if (advance) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      idx_q  <= idx_d;
    end
  end

  // Dropping the index MSB gives the modulo-2**ADDR_W wrap for free.
  assign addr = base_q + idx_q[ADDR_W-1:0];
  assign last = (idx_q == last_idx);

endmodule

// File: rtl/ram_dma_engine.sv
// ram_dma_engine: block-command initiator for one synchronous single-port RAM.
// Runs one FILL / COPY / SUM command at a time and owns the RAM bus while busy.
//   clk, rst_n      : clock shared with the RAM, asynchronous active-low reset
//   start, op       : command strobe (sampled in IDLE only) and opcode
//   src_addr, dst_addr, len, fill_data : command operands, captured on start
//   busy, done      : busy from the cycle after start; 1-cycle done pulse
//   error           : bad opcode or length, valid with done, held to next start
//   result          : SUM total (mod 2**DATA_W), held to next start
//   mem             : RAM bus (ram_dma_engine_if.master)
//   cycle_count     : busy-cycle counter, present only when the macro
//                     RAM_DMA_CYCLE_COUNT_EN is defined
module ram_dma_engine
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] result,
`ifdef RAM_DMA_CYCLE_COUNT_EN
  output logic [7:0]        cycle_count,
`endif
  ram_dma_engine_if.master  mem
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              sum_pend_q, sum_pend_d;

  logic              accept;
  logic              src_adv, dst_adv;
  logic              src_last, dst_last;
  logic [ADDR_W-1:0] src_cur, dst_cur;
  logic [LEN_W-1:0]  last_idx;

  assign accept   = start && (state_q == ST_IDLE);
  assign last_idx = len_q - LEN_W'(1);

  ram_dma_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_src_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .base_in  (src_addr),
    .advance  (src_adv),
    .last_idx (last_idx),
    .addr     (src_cur),
    .last     (src_last)
  );

  ram_dma_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dst_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .base_in  (dst_addr),
    .advance  (dst_adv),
    .last_idx (last_idx),
    .addr     (dst_cur),
    .last     (dst_last)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    fill_d   = fill_q;
    error_d  = error_q;
    result_d = result_q;
    src_adv  = 1'b0;
    dst_adv  = 1'b0;

    // Read data lags its SUM_R address by one cycle; sum_pend_q marks that
    // the word on mem_rdata belongs to the running SUM.
    sum_pend_d = (state_q == ST_SUM_R);
    if (sum_pend_q) begin
      result_d = result_q + mem.mem_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = len;
          fill_d   = fill_data;
          error_d  = 1'b0;
          result_d = '0;
          if ((op == OP_RSVD) || (len > MAX_LEN)) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            case (op)
              OP_FILL: state_d = ST_FILL_W;
              OP_COPY: state_d = ST_COPY_R;
              default: state_d = ST_SUM_R;
            endcase
          end
        end
      end
      ST_FILL_W: begin
        dst_adv = 1'b1;
        if (dst_last) state_d = ST_DONE;
      end
      ST_COPY_R: begin
        state_d = ST_COPY_W;
      end
      ST_COPY_W: begin
        src_adv = 1'b1;
        dst_adv = 1'b1;
        state_d = dst_last ? ST_DONE : ST_COPY_R;
      end
      ST_SUM_R: begin
        src_adv = 1'b1;
        if (src_last) state_d = ST_SUM_ACC;
      end
      ST_SUM_ACC: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      fill_q     <= '0;
      error_q    <= 1'b0;
      result_q   <= '0;
      sum_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      error_q    <= error_d;
      result_q   <= result_d;
      sum_pend_q <= sum_pend_d;
    end
  end

  // RAM bus is decoded from registered state only, so an asynchronous reset
  // forces writeOn, address and data to zero immediately.
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    case (state_q)
      ST_FILL_W: begin
        bus_addr  = dst_cur;
        bus_wdata = fill_q;
        bus_we    = 1'b1;
      end
      ST_COPY_R: begin
        bus_addr = src_cur;
      end
      ST_COPY_W: begin
        bus_addr  = dst_cur;
        bus_wdata = mem.mem_rdata;
        bus_we    = 1'b1;
      end
      ST_SUM_R: begin
        bus_addr = src_cur;
      end
      default: ;
    endcase
  end

  assign mem.mem_address = bus_addr;
  assign mem.mem_wdata   = bus_wdata;
  assign mem.mem_writeOn = bus_we;

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign error  = error_q;
  assign result = result_q;

`ifdef RAM_DMA_CYCLE_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`endif

endmodule
